branch_target_unit: RTL and testbench

//   Parametrised successor to the single-cycle branch adder.

---
 rtl/btu_pkg.sv | 27 ++
 rtl/btu_cond_eval.sv | 33 +++
 rtl/branch_target_unit.sv | 173 +++++++++++++++++
 tb/tb_branch_target_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btu_pkg.sv
// Shared definitions for branch_target_unit: resolve opcodes, BTB counter
// constants and the BTB entry layout.
package btu_pkg;

  localparam logic [2:0] BTU_OP_BEQ  = 3'd0;
  localparam logic [2:0] BTU_OP_BNE  = 3'd1;
  localparam logic [2:0] BTU_OP_BLEZ = 3'd2;
  localparam logic [2:0] BTU_OP_BGTZ = 3'd3;
  localparam logic [2:0] BTU_OP_BLTZ = 3'd4;
  localparam logic [2:0] BTU_OP_BGEZ = 3'd5;

  localparam logic [1:0] CTR_WEAK_T = 2'b10;
  localparam logic [1:0] CTR_MAX    = 2'b11;
  localparam logic [1:0] CTR_MIN    = 2'b00;

  // Tag/target fields are sized for the widest supported XLEN; the top
  // module only uses the low TAG_W / XLEN bits of each.
  localparam int BTU_MAX_W = 64;

  typedef struct packed {
    logic                 valid;
    logic [BTU_MAX_W-1:0] tag;
    logic [BTU_MAX_W-1:0] target;
    logic [1:0]           ctr;
  } btb_entry_t;

endpackage

// File: rtl/btu_cond_eval.sv
// Combinational branch condition evaluator; the sign tests compare rs
// against zero as a signed value.
module btu_cond_eval
  import btu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs,
  input  logic [XLEN-1:0] rt,
  output logic            taken
);

  logic rs_neg;
  logic rs_zero;

  assign rs_neg  = rs[XLEN-1];
  assign rs_zero = (rs == '0);

  always_comb begin
    taken = 1'b0;
    case (op)
      BTU_OP_BEQ:  taken = (rs == rt);
      BTU_OP_BNE:  taken = (rs != rt);
      BTU_OP_BLEZ: taken = rs_neg || rs_zero;
      BTU_OP_BGTZ: taken = !rs_neg && !rs_zero;
      BTU_OP_BLTZ: taken = rs_neg;
      BTU_OP_BGEZ: taken = !rs_neg;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_target_unit.sv
// Branch target/condition resolution with registered PC redirect and a
// direct-mapped BTB for fetch prediction. Optional BTU_PERF_CNT_EN adds counters.
module branch_target_unit
  import btu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int IMM_W     = 16,
  parameter int SHIFT     = 2,
  parameter int BTB_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  fetch_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             res_valid,
  input  logic [2:0]       res_op,
  input  logic [XLEN-1:0]  res_pc,
  input  logic [IMM_W-1:0] res_imm,
  input  logic [XLEN-1:0]  res_rs,
  input  logic [XLEN-1:0]  res_rt,
  input  logic             res_pred_taken,
  input  logic [XLEN-1:0]  res_pred_target,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             br_taken_q,
  input  logic             flush
`ifdef BTU_PERF_CNT_EN
  ,
  output logic [31:0]      perf_branches,
  output logic [31:0]      perf_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - SHIFT - IDX_W;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == CTR_MAX) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == CTR_MIN) ? c : c - 2'd1;
  endfunction

  btb_entry_t btb_q [BTB_DEPTH];
  btb_entry_t btb_d [BTB_DEPTH];

  // Fetch-side lookup sees the array as it stood before this cycle's update.
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx = fetch_pc[SHIFT +: IDX_W];
  assign f_tag = fetch_pc[XLEN-1 -: TAG_W];
  assign f_hit = btb_q[f_idx].valid && (btb_q[f_idx].tag[TAG_W-1:0] == f_tag);

  assign pred_taken  = f_hit && btb_q[f_idx].ctr[1];
  assign pred_target = f_hit ? btb_q[f_idx].target[XLEN-1:0] : fetch_pc + XLEN'(4);

  logic signed [XLEN-1:0] imm_ext;
  logic [XLEN-1:0]        br_off;
  logic [XLEN-1:0]        fallthrough;
  logic [XLEN-1:0]        target;
  logic                   cond_taken;
  logic                   taken;
  logic                   mispredict;

  assign imm_ext     = XLEN'($signed(res_imm));
  assign br_off      = imm_ext << SHIFT;
  assign fallthrough = res_pc + XLEN'(4);
  assign target      = fallthrough + br_off;

  btu_cond_eval #(.XLEN(XLEN)) u_cond (
    .op    (res_op),
    .rs    (res_rs),
    .rt    (res_rt),
    .taken (cond_taken)
  );

  assign taken      = res_valid && cond_taken;
  assign mispredict = res_valid &&
                      ((taken != res_pred_taken) || (taken && (res_pred_target != target)));

  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            br_taken_d;

  always_comb begin
    redirect_valid_d = mispredict;
    redirect_pc_d    = redirect_pc_q;
    br_taken_d       = br_taken_q;
    if (res_valid) begin
      redirect_pc_d = taken ? target : fallthrough;
      br_taken_d    = taken;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_hit;

  assign r_idx = res_pc[SHIFT +: IDX_W];
  assign r_tag = res_pc[XLEN-1 -: TAG_W];
  assign r_hit = btb_q[r_idx].valid && (btb_q[r_idx].tag[TAG_W-1:0] == r_tag);

  // Flush takes priority over any allocation/update in the same cycle.
  always_comb begin
    btb_d = btb_q;
    if (flush) begin
      for (int i = 0; i < BTB_DEPTH; i++) btb_d[i].valid = 1'b0;
    end else if (res_valid) begin
      if (taken) begin
        btb_d[r_idx].target = BTU_MAX_W'(target);
        if (r_hit) begin
          btb_d[r_idx].ctr = ctr_inc(btb_q[r_idx].ctr);
        end else begin
          btb_d[r_idx].valid = 1'b1;
          btb_d[r_idx].tag   = BTU_MAX_W'(r_tag);
          btb_d[r_idx].ctr   = CTR_WEAK_T;
        end
      end else if (r_hit) begin
        btb_d[r_idx].ctr = ctr_dec(btb_q[r_idx].ctr);
      end
    end
  end

  // Only valid bits and redirect state need a reset; BTB payload is qualified by valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) btb_q[i].valid <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      br_taken_q       <= 1'b0;
    end else begin
      btb_q            <= btb_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      br_taken_q       <= br_taken_d;
    end
  end

`ifdef BTU_PERF_CNT_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] perf_br_q, perf_br_d;
  logic [31:0] perf_mis_q, perf_mis_d;

  always_comb begin
    perf_br_d  = res_valid  ? sat_inc32(perf_br_q)  : perf_br_q;
    perf_mis_d = mispredict ? sat_inc32(perf_mis_q) : perf_mis_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_br_q  <= '0;
      perf_mis_q <= '0;
    end else begin
      perf_br_q  <= perf_br_d;
      perf_mis_q <= perf_mis_d;
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mis_q;
`endif

endmodule

// File: tb/tb_branch_target_unit.sv
// Self-checking bench for branch_target_unit: directed scenarios plus random
// resolves compared against a behavioural BTB/redirect model.
module tb_branch_target_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid;
  logic [2:0]  res_op;
  logic [31:0] res_pc;
  logic [15:0] res_imm;
  logic [31:0] res_rs, res_rt;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        br_taken_q;
  logic        flush;
`ifdef BTU_PERF_CNT_EN
  logic [31:0] perf_branches, perf_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_target_unit dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_pc        (fetch_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .res_valid       (res_valid),
    .res_op          (res_op),
    .res_pc          (res_pc),
    .res_imm         (res_imm),
    .res_rs          (res_rs),
    .res_rt          (res_rt),
    .res_pred_taken  (res_pred_taken),
    .res_pred_target (res_pred_target),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .br_taken_q      (br_taken_q),
    .flush           (flush)
`ifdef BTU_PERF_CNT_EN
    ,
    .perf_branches   (perf_branches),
    .perf_mispredicts(perf_mispredicts)
`endif
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: BTB as plain arrays indexed by (pc/4) mod 16, tag pc/64.
  bit          m_vld [16];
  bit [31:0]   m_tag [16];
  bit [31:0]   m_tgt [16];
  int          m_ctr [16];
  bit          m_rv;
  bit [31:0]   m_rpc;
  bit          m_bt;
  int unsigned m_nbr, m_nmis;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
    m_rv = 0; m_rpc = 0; m_bt = 0; m_nbr = 0; m_nmis = 0;
  endtask

  function automatic bit cond(input int op, input bit [31:0] rs, input bit [31:0] rt);
    case (op)
      0: return rs == rt;
      1: return rs != rt;
      2: return $signed(rs) <= 0;
      3: return $signed(rs) > 0;
      4: return $signed(rs) < 0;
      5: return $signed(rs) >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit [31:0] btarget(input bit [31:0] pc, input bit [15:0] imm);
    int off;
    off = int'($signed(imm)) * 4;
    return pc + 32'd4 + off;
  endfunction

  task automatic model_lookup(input bit [31:0] pc, output bit pt, output bit [31:0] tg);
    int i;
    bit hit;
    i   = (pc / 4) % 16;
    hit = m_vld[i] && (m_tag[i] == pc / 64);
    pt  = hit && (m_ctr[i] >= 2);
    tg  = hit ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic model_step();
    bit tk, mis, hit;
    bit [31:0] tg;
    int i;
    tk  = res_valid && cond(res_op, res_rs, res_rt);
    tg  = btarget(res_pc, res_imm);
    mis = res_valid && ((tk != res_pred_taken) || (tk && res_pred_target != tg));
    if (res_valid) begin
      m_rpc = tk ? tg : res_pc + 32'd4;
      m_bt  = tk;
      m_nbr++;
    end
    if (mis) m_nmis++;
    m_rv = mis;
    i   = (res_pc / 4) % 16;
    hit = m_vld[i] && (m_tag[i] == res_pc / 64);
    if (flush) begin
      for (int k = 0; k < 16; k++) m_vld[k] = 1'b0;
    end else if (res_valid) begin
      if (tk && !hit) begin
        m_vld[i] = 1'b1; m_tag[i] = res_pc / 64; m_tgt[i] = tg; m_ctr[i] = 2;
      end else if (tk) begin
        m_tgt[i] = tg; m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
      end else if (hit) begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end
  endtask

  task automatic check_model();
    bit pt;
    bit [31:0] tg;
    model_lookup(fetch_pc, pt, tg);
    chk("pred_taken", pred_taken, pt);
    chk("pred_target", pred_target, tg);
    chk("redirect_valid", redirect_valid, m_rv);
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("br_taken_q", br_taken_q, m_bt);
`ifdef BTU_PERF_CNT_EN
    chk("perf_branches", perf_branches, m_nbr);
    chk("perf_mispredicts", perf_mispredicts, m_nmis);
`endif
  endtask

  task automatic cycle();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input int op, input bit [31:0] pc, input bit [15:0] imm,
                       input bit [31:0] rs, input bit [31:0] rt, input bit pt,
                       input bit [31:0] ptg, input bit [31:0] fpc);
    res_valid = 1'b1; res_op = 3'(op); res_pc = pc; res_imm = imm;
    res_rs = rs; res_rt = rt; res_pred_taken = pt; res_pred_target = ptg;
    fetch_pc = fpc; flush = 1'b0;
  endtask

  task automatic idle(input bit [31:0] fpc);
    res_valid = 1'b0; flush = 1'b0; fetch_pc = fpc;
  endtask

  function automatic bit [31:0] rand_pc();
    bit [31:0] base;
    base = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FF00 : 32'h0000_1000;
    return base + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 15) << 2);
  endfunction

  function automatic bit [31:0] rand_opnd();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pt;
    bit [31:0] tg, rpc, ptg;
    bit [15:0] imm;
    rst = 1'b1; flush = 1'b0; res_valid = 1'b0; res_op = 0; res_pc = 0; res_imm = 0;
    res_rs = 0; res_rt = 0; res_pred_taken = 0; res_pred_target = 0; fetch_pc = 32'h100;
    model_reset();
    #12;
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_pred_target", pred_target, 32'h104);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_br_taken", br_taken_q, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // BEQ taken, predicted not-taken
    drive(0, 32'h100, 16'h0003, 5, 5, 0, 0, 32'h100);
    cycle();
    chk("t2_redirect_valid", redirect_valid, 1);
    chk("t2_redirect_pc", redirect_pc, 32'h110);
    chk("t2_br_taken", br_taken_q, 1);
    idle(32'h100); #1;
    chk("t2_pred_taken", pred_taken, 1);
    chk("t2_pred_target", pred_target, 32'h110);

    // BNE backward-to-self, correctly predicted; then trained down
    drive(1, 32'h200, 16'hFFFF, 1, 2, 1, 32'h200, 32'h200);
    cycle();
    chk("t3_redirect_valid", redirect_valid, 0);
    chk("t3_redirect_pc", redirect_pc, 32'h200);
    cycle();
    drive(1, 32'h200, 16'hFFFF, 7, 7, 1, 32'h200, 32'h200);
    cycle();
    chk("t3_nt1_redirect", redirect_valid, 1);
    chk("t3_nt1_pc", redirect_pc, 32'h204);
    chk("t3_ctr2_pred", pred_taken, 1);
    cycle();
    idle(32'h200); #1;
    chk("t3_ctr1_pred", pred_taken, 0);
    chk("t3_ctr1_target", pred_target, 32'h200);

    // PC wrap and signed compare
    drive(5, 32'hFFFF_FFF8, 16'h0004, 0, 0, 0, 0, 32'h0);
    cycle();
    chk("t4_wrap_pc", redirect_pc, 32'h0000_000C);
    chk("t4_wrap_taken", br_taken_q, 1);
    drive(4, 32'h300, 16'h0000, 32'h8000_0000, 0, 0, 0, 32'h0);
    cycle();
    chk("t4_bltz_taken", br_taken_q, 1);

    // Aliasing on index 0
    drive(0, 32'h140, 16'h0008, 1, 1, 0, 0, 32'h100);
    cycle();
    idle(32'h100); #1;
    chk("t5_alias_miss_pt", pred_taken, 0);
    chk("t5_alias_miss_tg", pred_target, 32'h104);
    fetch_pc = 32'h140; #1;
    chk("t5_new_pt", pred_taken, 1);
    chk("t5_new_tg", pred_target, 32'h164);
    drive(0, 32'h100, 16'h0003, 1, 1, 0, 0, 32'h140); #1;
    chk("t5_same_cycle_pt", pred_taken, 1);
    chk("t5_same_cycle_tg", pred_target, 32'h164);
    cycle();
    idle(32'h140); #1;
    chk("t5_after_tg", pred_target, 32'h144);

    // Flush wins over a same-cycle allocation
    drive(0, 32'h180, 16'h0000, 1, 1, 0, 0, 32'h100);
    flush = 1'b1;
    cycle();
    foreach (tg[k]) ; // no-op keeps tg declared use simple
    idle(32'h100); #1;
    chk("t6_flush_100", pred_taken, 0);
    fetch_pc = 32'h180; #1;
    chk("t6_flush_180_pt", pred_taken, 0);
    chk("t6_flush_180_tg", pred_target, 32'h184);
    fetch_pc = 32'h0; #1;
    chk("t6_flush_wrap_tg", pred_target, 32'h4);

    // Async reset mid-stream
    drive(0, 32'h100, 16'h0003, 1, 1, 0, 0, 32'h100);
    cycle();
    chk("t6_pre_rst_rv", redirect_valid, 1);
    idle(32'h100);
    #2; rst = 1'b1; #1;
    chk("t6_async_rv", redirect_valid, 0);
    chk("t6_async_pc", redirect_pc, 0);
    chk("t6_async_pt", pred_taken, 0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Random resolves against the model
    for (int n = 0; n < 400; n++) begin
      rpc = rand_pc();
      imm = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 32) - 16);
      if ($urandom_range(0, 1) == 1) begin
        model_lookup(rpc, pt, ptg);
      end else begin
        pt  = 1'($urandom);
        ptg = ($urandom_range(0, 1) == 1) ? btarget(rpc, imm) : $urandom;
      end
      drive($urandom_range(0, 7), rpc, imm, rand_opnd(), rand_opnd(), pt, ptg, rand_pc());
      res_valid = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      cycle();
    end
    idle(32'h1000);
    cycle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
